// File: rtl/cart_bus_if_pkg.sv
// Shared definitions for the cartridge bus responder and its requesters.
//   cart_state_e  - bus-cycle FSM states
//   CART_RAM_*    - cart RAM window that qualifies /CS
//   LOGO_*        - header logo byte range read by the startup screen
package cart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } cart_state_e;

  localparam logic [15:0] CART_RAM_BASE = 16'hA000;
  localparam logic [15:0] CART_RAM_END  = 16'hBFFF;

  localparam logic [15:0] LOGO_START = 16'd260;
  localparam logic [15:0] LOGO_END   = 16'd307;

  function automatic logic is_cart_ram(input logic [15:0] addr);
    return (addr >= CART_RAM_BASE) && (addr <= CART_RAM_END);
  endfunction

endpackage

// File: rtl/cart_bus_if_if.sv
// Internal ROM request bus between requesters (master) and the cart responder (slave).
//   rom_addr/rom_wdata - request address and write data, valid with the pulse
//   rom_rd/rom_wr      - single-cycle request pulses
//   rom_data           - last read result
//   rom_bsy            - registered busy, high while a bus cycle runs
interface cart_bus_if_if;

  logic [15:0] rom_addr;
  logic        rom_rd;
  logic        rom_wr;
  logic [7:0]  rom_wdata;
  logic [7:0]  rom_data;
  logic        rom_bsy;

  modport master (
    output rom_addr, rom_rd, rom_wr, rom_wdata,
    input  rom_data, rom_bsy
  );

  modport slave (
    input  rom_addr, rom_rd, rom_wr, rom_wdata,
    output rom_data, rom_bsy
  );

endinterface

// File: rtl/cart_bus_if.sv
// Cartridge bus responder: turns rom_rd/rom_wr pulses into timed cart bus cycles.
//   clk_8m, rst   - system clock, synchronous active-high reset
//   rom           - request bus (slave side)
//   cart_a        - cartridge address, held after the cycle ends
//   cart_d_out/oe - write data and pad output enable (high only for writes)
//   cart_d_in     - data from cart pads, captured at the end of /RD
//   cart_rd_n/wr_n/cs_n - active-low strobes; /CS only for the cart RAM window
module cart_bus_if
  import cart_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned ACCESS_CYCLES = 3,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter int unsigned CNT_W         = 4
) (
  input  logic         clk_8m,
  input  logic         rst,
  cart_bus_if_if.slave rom,
  output logic [15:0]  cart_a,
  output logic [7:0]   cart_d_out,
  output logic         cart_d_oe,
  input  logic [7:0]   cart_d_in,
  output logic         cart_rd_n,
  output logic         cart_wr_n,
  output logic         cart_cs_n
);

  localparam logic [CNT_W-1:0] SetupLast  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] AccessLast = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLD_CYCLES - 1);

  cart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_rd_q, is_rd_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             bsy_q, bsy_d;
  logic             rd_n_q, rd_n_d;
  logic             wr_n_q, wr_n_d;
  logic             cs_n_q, cs_n_d;
  logic             oe_q, oe_d;

  always_ff @(posedge clk_8m) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      is_rd_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      bsy_q   <= 1'b0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_rd_q <= is_rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      bsy_q   <= bsy_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      cs_n_q  <= cs_n_d;
      oe_q    <= oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    is_rd_d = is_rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    bsy_d   = bsy_q;
    rd_n_d  = rd_n_q;
    wr_n_d  = wr_n_q;
    cs_n_d  = cs_n_q;
    oe_d    = oe_q;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rom.rom_rd || rom.rom_wr) begin
          // Read has priority; a simultaneous write is dropped.
          state_d = StSetup;
          is_rd_d = rom.rom_rd;
          addr_d  = rom.rom_addr;
          if (!rom.rom_rd) wdata_d = rom.rom_wdata;
          bsy_d   = 1'b1;
          cs_n_d  = ~is_cart_ram(rom.rom_addr);
          oe_d    = ~rom.rom_rd;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StStrobe;
          cnt_d   = '0;
          if (is_rd_q) rd_n_d = 1'b0;
          else         wr_n_d = 1'b0;
        end
      end
      StStrobe: begin
        if (cnt_q == AccessLast) begin
          state_d = StHold;
          cnt_d   = '0;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          if (is_rd_q) rdata_d = cart_d_in;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          oe_d    = 1'b0;
          bsy_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign rom.rom_data = rdata_q;
  assign rom.rom_bsy  = bsy_q;
  assign cart_a       = addr_q;
  assign cart_d_out   = wdata_q;
  assign cart_d_oe    = oe_q;
  assign cart_rd_n    = rd_n_q;
  assign cart_wr_n    = wr_n_q;
  assign cart_cs_n    = cs_n_q;

endmodule

// File: tb/tb_cart_bus_if.sv
// Bench for cart_bus_if: directed cases plus random traffic, every cycle compared
// against a transaction-level model that knows only the phase timing of a bus cycle.
module tb_cart_bus_if;
  import cart_pkg::*;

  localparam int S     = 1;
  localparam int A     = 3;
  localparam int H     = 1;
  localparam int TOTAL = S + A + H;

  logic        clk_8m = 1'b0;
  logic        rst;
  logic [15:0] cart_a;
  logic [7:0]  cart_d_out;
  logic        cart_d_oe;
  logic [7:0]  cart_d_in;
  logic        cart_rd_n;
  logic        cart_wr_n;
  logic        cart_cs_n;

  cart_bus_if_if rom_bus ();

  cart_bus_if #(
    .SETUP_CYCLES (S),
    .ACCESS_CYCLES(A),
    .HOLD_CYCLES  (H),
    .CNT_W        (4)
  ) dut (
    .clk_8m    (clk_8m),
    .rst       (rst),
    .rom       (rom_bus.slave),
    .cart_a    (cart_a),
    .cart_d_out(cart_d_out),
    .cart_d_oe (cart_d_oe),
    .cart_d_in (cart_d_in),
    .cart_rd_n (cart_rd_n),
    .cart_wr_n (cart_wr_n),
    .cart_cs_n (cart_cs_n)
  );

  always #5 clk_8m = ~clk_8m;

  // Cartridge ROM contents: a fixed logo byte plus an address hash elsewhere.
  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    if (a == 16'h0104) return 8'hCE;
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  assign cart_d_in = rom_byte(cart_a);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, k = edges elapsed since acceptance.
  bit          m_active = 0;
  bit          m_is_rd  = 0;
  int          m_k      = 0;
  logic [15:0] m_a      = '0;
  logic [7:0]  m_wd     = '0;
  logic [7:0]  m_data   = '0;
  int          n_rd_pulses;

  task automatic model_edge(input logic rd, input logic wr, input logic [15:0] a,
                            input logic [7:0] wd, input logic r);
    if (r) begin
      m_active = 0;
      m_a      = '0;
      m_wd     = '0;
      m_data   = '0;
    end else if (m_active) begin
      m_k++;
      if (m_is_rd && m_k == S + A) m_data = rom_byte(m_a);
      if (m_k == TOTAL) m_active = 0;  // request on this edge is ignored
    end else if (rd || wr) begin
      m_active = 1;
      m_k      = 0;
      m_is_rd  = rd;
      m_a      = a;
      if (!rd) m_wd = wd;
    end
  endtask

  task automatic check_all();
    bit strobe_on;
    strobe_on = m_active && m_k >= S && m_k < S + A;
    check("rom_bsy",    32'(rom_bus.rom_bsy), 32'(m_active));
    check("rom_data",   32'(rom_bus.rom_data), 32'(m_data));
    check("cart_a",     32'(cart_a), 32'(m_a));
    check("cart_d_out", 32'(cart_d_out), 32'(m_wd));
    check("cart_d_oe",  32'(cart_d_oe), 32'(m_active && !m_is_rd));
    check("cart_rd_n",  32'(cart_rd_n), 32'(!(strobe_on && m_is_rd)));
    check("cart_wr_n",  32'(cart_wr_n), 32'(!(strobe_on && !m_is_rd)));
    check("cart_cs_n",  32'(cart_cs_n), 32'(!(m_active && is_cart_ram(m_a))));
    if (!cart_rd_n) n_rd_pulses++;
  endtask

  // Called at a negedge: drive inputs, take one posedge, then compare.
  task automatic cycle(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [7:0] wd, input logic r);
    rst               = r;
    rom_bus.rom_rd    = rd;
    rom_bus.rom_wr    = wr;
    rom_bus.rom_addr  = a;
    rom_bus.rom_wdata = wd;
    @(posedge clk_8m);
    model_edge(rd, wr, a, wd, r);
    @(negedge clk_8m);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'hFFFF, 8'hEE, 1'b0);
  endtask

  task automatic read(input logic [15:0] a);
    cycle(1'b1, 1'b0, a, 8'h00, 1'b0);
    idle(TOTAL);
  endtask

  task automatic write(input logic [15:0] a, input logic [7:0] d);
    cycle(1'b0, 1'b1, a, d, 1'b0);
    idle(TOTAL);
  endtask

  initial begin
    logic [15:0] ra;
    logic        r_rd, r_wr, r_rst;

    rst = 1'b1;
    rom_bus.rom_rd = 1'b0;
    rom_bus.rom_wr = 1'b0;
    rom_bus.rom_addr = '0;
    rom_bus.rom_wdata = '0;
    @(negedge clk_8m);
    cycle(1'b0, 1'b0, 16'h0, 8'h0, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 8'h0, 1'b1);

    // Reset mid-strobe before any read completes: rom_data must stay 0.
    cycle(1'b1, 1'b0, 16'h0150, 8'h00, 1'b0);
    idle(2);
    cycle(1'b0, 1'b0, 16'h0, 8'h0, 1'b1);
    check("abort_rom_data", 32'(rom_bus.rom_data), 32'h0);
    idle(2);

    read(16'h0104);
    check("logo_byte", 32'(rom_bus.rom_data), 32'hCE);
    write(16'h2000, 8'h05);
    read(16'hA010);
    write(16'hC000, 8'h3C);
    write(16'hA000, 8'h77);
    read(16'hBFFF);
    read(16'h9FFF);

    // Re-requests at E2 and E5 are dropped; E6 is accepted.
    n_rd_pulses = 0;
    cycle(1'b1, 1'b0, 16'h0134, 8'h00, 1'b0);
    idle(1);
    cycle(1'b1, 1'b0, 16'h0200, 8'h00, 1'b0);
    idle(2);
    cycle(1'b1, 1'b0, 16'h0300, 8'h00, 1'b0);
    check("rd_pulse_count", 32'(n_rd_pulses), 32'(A));
    cycle(1'b1, 1'b0, 16'h0400, 8'h00, 1'b0);
    check("e6_accepted", 32'(rom_bus.rom_bsy), 32'h1);
    idle(TOTAL);

    // Simultaneous read and write: read only.
    cycle(1'b1, 1'b1, 16'hA123, 8'h99, 1'b0);
    idle(TOTAL);

    for (int a = LOGO_START; a <= LOGO_END; a++) begin
      read(16'(a));
      check("logo_sweep", 32'(rom_bus.rom_data), 32'(rom_byte(16'(a))));
    end

    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 16'($urandom_range(0, 16'h7FFF));
        1: ra = 16'($urandom_range(16'hA000, 16'hBFFF));
        2: ra = 16'($urandom_range(16'hC000, 16'hFFFF));
        default: begin
          case ($urandom_range(0, 3))
            0: ra = 16'h9FFF;
            1: ra = 16'hA000;
            2: ra = 16'hBFFF;
            default: ra = 16'hC000;
          endcase
        end
      endcase
      r_rd  = ($urandom_range(0, 3) == 0);
      r_wr  = ($urandom_range(0, 3) == 0);
      r_rst = ($urandom_range(0, 199) == 0);
      cycle(r_rd, r_wr, ra, 8'($urandom), r_rst);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
